// File: rtl/arb_resp_pkg.sv
// Package: arb_resp_pkg
//
// Shared types and sizing helpers for the arbiter response router.
//   port_id_t      - identifies which arbiter input won a request (0 or 1)
//   DEPTH_DEFAULT  - default number of outstanding requests the router tracks
//   DATA_W_DEFAULT - default response payload width
//   cnt_w()        - width needed to hold an occupancy count from 0 up to depth inclusive
package arb_resp_pkg;

    typedef logic port_id_t;

    localparam int DEPTH_DEFAULT  = 4;
    localparam int DATA_W_DEFAULT = 64;

    // One extra bit so the count can represent "completely full" (== depth).
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_resp_router_tag_fifo.sv
// Module: tag_fifo
//
// Synchronous FIFO of port identifiers. Each entry remembers which requester
// owns the corresponding outstanding downstream request, in issue order.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-low
//   push     in   write push_id at the tail (ignored when full)
//   push_id  in   requester that owns the new request
//   pop      in   drop the head entry (ignored when empty)
//   head     out  owner of the oldest outstanding request (combinational)
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored entries
module tag_fifo
    import arb_resp_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEFAULT,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  port_id_t         push_id,
    input  logic             pop,
    output port_id_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    port_id_t         mem_q [DEPTH];
    port_id_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Internal guards keep the occupancy inside [0, DEPTH] even if a caller
    // asserts push/pop at the wrong time. DEPTH is a power of two, so the
    // pointers wrap naturally on overflow.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/arb_resp_router.sv
// Module: arb_resp_router
//
// Response return path for a 2-input priority arbiter. Every request the
// arbiter sends downstream has its winner recorded in a tag FIFO; in-order
// responses coming back are staged in a single output register and steered
// to the recorded requester. Requests are held off while the FIFO is full so
// that no response can ever arrive without an owner.
//
// Ports:
//   clock, reset                    clock and synchronous active-low reset
//   io_req_valid/chosen/ready       arbiter output handshake and winner id
//   io_down_valid/ready             request forwarded to the memory port
//   io_resp_valid/data/ready        response from the memory port
//   io_out_0_valid/ready            response handshake to requester 0
//   io_out_1_valid/ready            response handshake to requester 1
//   io_out_data                     staged payload, shared by both requesters
//   io_outstanding                  number of tags awaiting a response
//   io_err                          sticky: a response arrived with no tag
module arb_resp_router
    import arb_resp_pkg::*;
#(
    parameter int  DEPTH  = DEPTH_DEFAULT,
    parameter int  DATA_W = DATA_W_DEFAULT,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    input  logic              io_req_chosen,
    output logic              io_req_ready,
    output logic              io_down_valid,
    input  logic              io_down_ready,
    input  logic              io_resp_valid,
    input  logic [DATA_W-1:0] io_resp_data,
    output logic              io_resp_ready,
    output logic              io_out_0_valid,
    input  logic              io_out_0_ready,
    output logic              io_out_1_valid,
    input  logic              io_out_1_ready,
    output logic [DATA_W-1:0] io_out_data,
    output logic [CNT_W-1:0]  io_outstanding,
    output logic              io_err
);

    logic              full;
    logic              empty;
    port_id_t          head;
    logic              push;
    logic              pop;
    logic              sel_ready;
    logic              drain;

    logic              valid_q, valid_d;
    port_id_t          port_q, port_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_id (io_req_chosen),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (io_outstanding)
    );

    // Request gating and response acceptance. Handshakes are forced off while
    // reset is asserted so nothing enters the FIFO during reset. The output
    // stage can take a new response when it is empty or is being drained in
    // the same cycle, which gives one response per cycle when the target keeps
    // its ready high.
    always_comb begin
        io_down_valid = reset & io_req_valid & ~full;
        io_req_ready  = reset & io_down_ready & ~full;
        push          = io_req_valid & io_req_ready;

        sel_ready     = port_q ? io_out_1_ready : io_out_0_ready;
        drain         = valid_q & sel_ready;
        io_resp_ready = reset & ~empty & (~valid_q | drain);
        pop           = io_resp_valid & io_resp_ready;
    end

    // Output stage: a new response overwrites the stage only when accepted;
    // otherwise the staged payload is held until its requester takes it.
    always_comb begin
        valid_d = valid_q;
        port_d  = port_q;
        data_d  = data_q;
        err_d   = err_q | (io_resp_valid & empty);
        if (pop) begin
            valid_d = 1'b1;
            port_d  = head;
            data_d  = io_resp_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            port_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            port_q  <= port_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign io_out_0_valid = valid_q & (port_q == 1'b0);
    assign io_out_1_valid = valid_q & (port_q == 1'b1);
    assign io_out_data    = data_q;
    assign io_err         = err_q;

endmodule

// File: tb/tb_arb_resp_router.sv
// Testbench: tb_arb_resp_router
//
// Drives arb_resp_router with a table of directed vectors, several short
// hand-built sequences for the multi-cycle corners, and a randomized run.
// Expected outputs come from the table or from a queue-based reference model
// of the router that tracks outstanding owners and the staged response.
module tb_arb_resp_router;
    import arb_resp_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int CNT_W  = cnt_w(DEPTH);

    logic              clock = 1'b0;
    logic              reset;
    logic              io_req_valid;
    logic              io_req_chosen;
    logic              io_req_ready;
    logic              io_down_valid;
    logic              io_down_ready;
    logic              io_resp_valid;
    logic [DATA_W-1:0] io_resp_data;
    logic              io_resp_ready;
    logic              io_out_0_valid;
    logic              io_out_0_ready;
    logic              io_out_1_valid;
    logic              io_out_1_ready;
    logic [DATA_W-1:0] io_out_data;
    logic [CNT_W-1:0]  io_outstanding;
    logic              io_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rst_n;
        logic        rv;
        logic        ch;
        logic        dr;
        logic        sv;
        logic [63:0] sd;
        logic        r0;
        logic        r1;
    } in_t;

    typedef struct packed {
        logic        rr;
        logic        dv;
        logic        sr;
        logic        o0;
        logic        o1;
        logic [63:0] data;
        logic [31:0] outs;
        logic        err;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    // Reference model state: owners of outstanding requests in issue order,
    // the staged response, and the sticky error flag.
    logic        tags[$];
    logic        stg_v = 1'b0;
    logic        stg_p = 1'b0;
    logic [63:0] stg_d = '0;
    logic        m_err = 1'b0;

    arb_resp_router #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_req_valid   (io_req_valid),
        .io_req_chosen  (io_req_chosen),
        .io_req_ready   (io_req_ready),
        .io_down_valid  (io_down_valid),
        .io_down_ready  (io_down_ready),
        .io_resp_valid  (io_resp_valid),
        .io_resp_data   (io_resp_data),
        .io_resp_ready  (io_resp_ready),
        .io_out_0_valid (io_out_0_valid),
        .io_out_0_ready (io_out_0_ready),
        .io_out_1_valid (io_out_1_valid),
        .io_out_1_ready (io_out_1_ready),
        .io_out_data    (io_out_data),
        .io_outstanding (io_outstanding),
        .io_err         (io_err)
    );

    always #5 clock = ~clock;

    function automatic in_t mk_in(logic rst_n, logic rv, logic ch, logic dr, logic sv,
                                  logic [63:0] sd, logic r0, logic r1);
        in_t v;
        v.rst_n = rst_n; v.rv = rv; v.ch = ch; v.dr = dr;
        v.sv = sv; v.sd = sd; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    function automatic exp_t mk_exp(logic rr, logic dv, logic sr, logic o0, logic o1,
                                    logic [63:0] data, int outs, logic err);
        exp_t e;
        e.rr = rr; e.dv = dv; e.sr = sr; e.o0 = o0; e.o1 = o1;
        e.data = data; e.outs = 32'(outs); e.err = err;
        return e;
    endfunction

    // Outputs the model expects for this cycle's inputs given its current state.
    function automatic exp_t predict(in_t v);
        exp_t p;
        logic full;
        logic sel;
        full   = (tags.size() == DEPTH);
        sel    = stg_p ? v.r1 : v.r0;
        p.rr   = v.rst_n && v.dr && !full;
        p.dv   = v.rst_n && v.rv && !full;
        p.sr   = v.rst_n && (tags.size() != 0) && (!stg_v || sel);
        p.o0   = stg_v && !stg_p;
        p.o1   = stg_v && stg_p;
        p.data = stg_d;
        p.outs = 32'(tags.size());
        p.err  = m_err;
        return p;
    endfunction

    // Move the model across one rising edge using this cycle's handshakes.
    task automatic advance(input in_t v, input exp_t p);
        logic sel;
        sel = stg_p ? v.r1 : v.r0;
        if (!v.rst_n) begin
            tags.delete();
            stg_v = 1'b0;
            stg_p = 1'b0;
            stg_d = '0;
            m_err = 1'b0;
        end else begin
            if (tags.size() == 0 && v.sv) m_err = 1'b1;
            if (v.sv && p.sr) begin
                stg_p = tags.pop_front();
                stg_v = 1'b1;
                stg_d = v.sd;
            end else if (stg_v && sel) begin
                stg_v = 1'b0;
            end
            if (v.rv && p.rr) tags.push_back(v.ch);
        end
    endtask

    task automatic applyStimulus(input in_t v);
        reset          = v.rst_n;
        io_req_valid   = v.rv;
        io_req_chosen  = v.ch;
        io_down_ready  = v.dr;
        io_resp_valid  = v.sv;
        io_resp_data   = v.sd;
        io_out_0_ready = v.r0;
        io_out_1_ready = v.r1;
    endtask

    task automatic cmp(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s %s: got=%0h expected=%0h", tag, name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        cmp(tag, "req_ready",   64'(io_req_ready),   64'(e.rr));
        cmp(tag, "down_valid",  64'(io_down_valid),  64'(e.dv));
        cmp(tag, "resp_ready",  64'(io_resp_ready),  64'(e.sr));
        cmp(tag, "out_0_valid", 64'(io_out_0_valid), 64'(e.o0));
        cmp(tag, "out_1_valid", 64'(io_out_1_valid), 64'(e.o1));
        cmp(tag, "out_data",    io_out_data,         e.data);
        cmp(tag, "outstanding", 64'(io_outstanding), 64'(e.outs));
        cmp(tag, "err",         64'(io_err),         64'(e.err));
    endtask

    // One clock cycle: drive inputs after the falling edge, compare shortly
    // after, then update the model at the rising edge.
    task automatic step(input in_t v, input bit chk, input bit use_tab,
                        input exp_t e_tab, input string tag);
        exp_t p;
        @(negedge clock);
        applyStimulus(v);
        #1;
        p = predict(v);
        if (chk) checkOutput(use_tab ? e_tab : p, tag);
        @(posedge clock);
        advance(v, p);
    endtask

    task automatic mstep(input in_t v, input string tag);
        step(v, 1'b1, 1'b0, '0, tag);
    endtask

    vec_t vecs[10];

    initial begin
        applyStimulus(mk_in(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset then idle; the first reset cycle only establishes known state.
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, '0, "rst0");
        step(mk_in(0, 1, 1, 1, 1, 64'h55, 1, 1), 1'b1, 1'b1,
             mk_exp(0, 0, 0, 0, 0, 0, 0, 0), "rst1");
        step(mk_in(1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1,
             mk_exp(0, 0, 0, 0, 0, 0, 0, 0), "idle");

        // Ordered routing: owners 0,1,1,0 then responses A,B,C,D.
        vecs[0] = '{mk_in(1, 1, 0, 1, 0, 0,     1, 1), mk_exp(1, 1, 0, 0, 0, 0,     0, 0)};
        vecs[1] = '{mk_in(1, 1, 1, 1, 0, 0,     1, 1), mk_exp(1, 1, 1, 0, 0, 0,     1, 0)};
        vecs[2] = '{mk_in(1, 1, 1, 1, 0, 0,     1, 1), mk_exp(1, 1, 1, 0, 0, 0,     2, 0)};
        vecs[3] = '{mk_in(1, 1, 0, 1, 0, 0,     1, 1), mk_exp(1, 1, 1, 0, 0, 0,     3, 0)};
        vecs[4] = '{mk_in(1, 0, 0, 1, 1, 64'hA, 1, 1), mk_exp(0, 0, 1, 0, 0, 0,     4, 0)};
        vecs[5] = '{mk_in(1, 0, 0, 1, 1, 64'hB, 1, 1), mk_exp(1, 0, 1, 1, 0, 64'hA, 3, 0)};
        vecs[6] = '{mk_in(1, 0, 0, 1, 1, 64'hC, 1, 1), mk_exp(1, 0, 1, 0, 1, 64'hB, 2, 0)};
        vecs[7] = '{mk_in(1, 0, 0, 1, 1, 64'hD, 1, 1), mk_exp(1, 0, 1, 0, 1, 64'hC, 1, 0)};
        vecs[8] = '{mk_in(1, 0, 0, 1, 0, 0,     1, 1), mk_exp(1, 0, 0, 1, 0, 64'hD, 0, 0)};
        vecs[9] = '{mk_in(1, 0, 0, 1, 0, 0,     1, 1), mk_exp(1, 0, 0, 0, 0, 64'hD, 0, 0)};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].i, 1'b1, 1'b1, vecs[i].e, $sformatf("route%0d", i));
        end

        // Full: four pushes, a blocked fifth, a pop that does not unblock the
        // same cycle, then the push goes through on the following cycle.
        for (int i = 0; i < 4; i++) mstep(mk_in(1, 1, i[0], 1, 0, 0, 1, 1), "fill");
        mstep(mk_in(1, 1, 1, 1, 0, 0, 1, 1), "full_block");
        mstep(mk_in(1, 1, 1, 1, 1, 64'h77, 1, 1), "full_pop");
        mstep(mk_in(1, 1, 1, 1, 0, 0, 1, 1), "full_unblock");
        for (int i = 0; i < 7; i++) mstep(mk_in(1, 0, 0, 1, 1, 64'h100 + 64'(i), 1, 1), "flush");

        // Backpressure on requester 1 while a response for requester 0 waits.
        mstep(mk_in(1, 1, 1, 1, 0, 0, 1, 0), "bp_push1");
        mstep(mk_in(1, 1, 0, 1, 0, 0, 1, 0), "bp_push0");
        mstep(mk_in(1, 0, 0, 1, 1, 64'h11, 1, 0), "bp_stage");
        for (int i = 0; i < 3; i++) mstep(mk_in(1, 0, 0, 1, 1, 64'h22, 1, 0), "bp_hold");
        mstep(mk_in(1, 0, 0, 1, 1, 64'h22, 1, 1), "bp_release");
        mstep(mk_in(1, 0, 0, 1, 0, 0, 1, 1), "bp_drain");
        mstep(mk_in(1, 0, 0, 1, 0, 0, 1, 1), "bp_idle");

        // Unexpected response while empty: stalled, error is sticky until reset.
        mstep(mk_in(1, 0, 0, 1, 1, 64'hBAD, 1, 1), "unexp");
        for (int i = 0; i < 3; i++) mstep(mk_in(1, 0, 0, 1, 0, 0, 1, 1), "err_sticky");
        mstep(mk_in(0, 0, 0, 1, 0, 0, 1, 1), "err_rst");
        mstep(mk_in(1, 0, 0, 1, 0, 0, 1, 1), "err_clear");

        // Mid-operation reset with tags outstanding and a staged response.
        for (int i = 0; i < 3; i++) mstep(mk_in(1, 1, i[0], 1, 0, 0, 0, 0), "mid_push");
        mstep(mk_in(1, 0, 0, 1, 1, 64'h33, 0, 0), "mid_stage");
        mstep(mk_in(0, 1, 1, 1, 1, 64'h44, 0, 0), "mid_rst");
        mstep(mk_in(1, 1, 1, 1, 0, 0, 1, 1), "post_push1");
        mstep(mk_in(1, 1, 0, 1, 0, 0, 1, 1), "post_push0");
        mstep(mk_in(1, 0, 0, 1, 1, 64'h5A, 1, 1), "post_pop1");
        mstep(mk_in(1, 0, 0, 1, 1, 64'h5B, 1, 1), "post_pop0");
        mstep(mk_in(1, 0, 0, 1, 0, 0, 1, 1), "post_out0");
        mstep(mk_in(1, 0, 0, 1, 0, 0, 1, 1), "post_idle");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            in_t v;
            v.rst_n = ($urandom_range(0, 59) != 0);
            v.rv    = 1'($urandom);
            v.ch    = 1'($urandom);
            v.dr    = ($urandom_range(0, 3) != 0);
            v.sv    = ($urandom_range(0, 2) != 0);
            v.sd    = {$urandom, $urandom};
            v.r0    = ($urandom_range(0, 3) != 0);
            v.r1    = ($urandom_range(0, 3) != 0);
            mstep(v, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
